// File: rtl/slave_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing the slave message TX channel
// between NUM_REQ sources: header strobe, registered data beats, ack or timeout.
module slave_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_BYTES   = 4096
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [16*NUM_REQ-1:0] req_byte_num_i,
  input  logic [NUM_REQ-1:0]    req_data_vld_i,
  input  logic [8*NUM_REQ-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [NUM_REQ-1:0]    err_o,
  output logic                  slave_tx_byte_num_en_o,
  output logic [15:0]           slave_tx_byte_num_o,
  output logic                  slave_tx_en_o,
  output logic [7:0]            slave_tx_data_o,
  input  logic                  slave_tx_ack_i,
  output logic                  busy_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StHdr, StData, StWaitAck, StRel} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     idx_q, idx_d, rr_q, rr_d;
  logic [15:0]         len_q, len_d, cnt_q, cnt_d, byte_num_q, byte_num_d;
  logic [31:0]         timer_q, timer_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          tx_data_q, tx_data_d;

  logic                found;
  logic [IdxW-1:0]     pick, cand;
  logic [15:0]         req_len;
  logic                beat_vld;
  logic [7:0]          beat_data;
  logic                len_bad, hdr_strobe, hdr_err, ack_hit, timeout_hit;

  // First requesting index at or above the round-robin pointer, with wrap.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign req_len   = req_byte_num_i[16*pick +: 16];
  assign beat_vld  = req_data_vld_i[idx_q];
  assign beat_data = req_data_i[8*idx_q +: 8];
  assign len_bad   = (len_q == 16'd0) || (32'(len_q) > MAX_BYTES);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    byte_num_d  = byte_num_q;
    timer_d     = timer_q;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    hdr_strobe  = 1'b0;
    hdr_err     = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << pick;
          idx_d   = pick;
          len_d   = req_len;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (len_bad) begin
          hdr_err = 1'b1;
          grant_d = '0;
          state_d = StRel;
        end else begin
          hdr_strobe = 1'b1;
          byte_num_d = len_q;
          cnt_d      = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat_vld) begin
          tx_en_d   = 1'b1;
          tx_data_d = beat_data;
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == len_q) begin
            timer_d = '0;
            state_d = StWaitAck;
          end
        end
      end
      StWaitAck: begin
        if (slave_tx_ack_i) begin
          ack_hit = 1'b1;
          grant_d = '0;
          state_d = StRel;
        end else if (timer_q == TIMEOUT_CYC) begin
          timeout_hit = 1'b1;
          grant_d     = '0;
          state_d     = StRel;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StRel: begin
        rr_d    = (32'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      idx_q      <= '0;
      rr_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      byte_num_q <= '0;
      timer_q    <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      byte_num_q <= byte_num_d;
      timer_q    <= timer_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Completion pulses are combinational so a requester can drop req_i during REL.
  assign grant_o                = grant_q;
  assign done_o                 = ack_hit ? grant_q : '0;
  assign err_o                  = (hdr_err || timeout_hit) ? grant_q : '0;
  assign slave_tx_byte_num_en_o = hdr_strobe;
  assign slave_tx_byte_num_o    = hdr_strobe ? len_q : byte_num_q;
  assign slave_tx_en_o          = tx_en_q;
  assign slave_tx_data_o        = tx_data_q;
  assign busy_o                 = (state_q != StIdle);

endmodule

// File: tb/tb_slave_tx_arbiter.sv
// Bench for slave_tx_arbiter: directed frames, a queue scoreboard with a
// round-robin grant model checked every cycle, and literal timing checks.
module tb_slave_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] blen = '0;
  logic [3:0]  vld = '0;
  logic [31:0] bdata = '0;
  logic        ack = 1'b0;

  logic [3:0]  grant_o, done_o, err_o;
  logic        byte_num_en_o, tx_en_o, busy_o;
  logic [15:0] byte_num_o;
  logic [7:0]  tx_data_o;

  slave_tx_arbiter #(
    .NUM_REQ    (4),
    .TIMEOUT_CYC(16),
    .MAX_BYTES  (4096)
  ) dut (
    .clk_sys_i             (clk),
    .rst_n_i               (rst_n),
    .req_i                 (req),
    .req_byte_num_i        (blen),
    .req_data_vld_i        (vld),
    .req_data_i            (bdata),
    .grant_o               (grant_o),
    .done_o                (done_o),
    .err_o                 (err_o),
    .slave_tx_byte_num_en_o(byte_num_en_o),
    .slave_tx_byte_num_o   (byte_num_o),
    .slave_tx_en_o         (tx_en_o),
    .slave_tx_data_o       (tx_data_o),
    .slave_tx_ack_i        (ack),
    .busy_o                (busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_hdr[$];
  int exp_byte[$];
  int exp_evt[$];   // requester index, +16 when the outcome is an error
  int tx_seen = 0;
  int hdr_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input longint act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, expected nothing at %0t", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int c = (p + i) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] beat(input logic [7:0] base, input int i);
    return base + 8'(8'h11 * i);
  endfunction

  // Reference model: round-robin pointer plus expected-event queues.
  int         rr_m = 0;
  int         cur_m = 0;
  int         p_m, e_m;
  logic [3:0] prev_req = '0;
  logic [3:0] prev_grant = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rr_m = 0;
      cur_m = 0;
      prev_grant = '0;
      prev_req = req;
    end else begin
      if (grant_o != 4'd0 && prev_grant == 4'd0) begin
        p_m = rr_pick(prev_req, rr_m);
        check("model_grant", grant_o, (p_m < 0) ? 0 : (1 << p_m));
        cur_m = (p_m < 0) ? 0 : p_m;
      end
      if (byte_num_en_o) begin
        hdr_seen++;
        if (exp_hdr.size() == 0) note_fail("hdr_unexpected", byte_num_o);
        else check("model_hdr_len", byte_num_o, exp_hdr.pop_front());
      end
      if (tx_en_o) begin
        tx_seen++;
        if (exp_byte.size() == 0) note_fail("tx_unexpected", tx_data_o);
        else check("model_tx_data", tx_data_o, exp_byte.pop_front());
      end
      if ((done_o | err_o) != 4'd0) begin
        if (exp_evt.size() == 0) note_fail("evt_unexpected", {done_o, err_o});
        else begin
          e_m = exp_evt.pop_front();
          check("model_done_err", {done_o, err_o},
                (e_m >= 16) ? (1 << (e_m - 16)) : (1 << (e_m + 4)));
          rr_m = (cur_m + 1) % 4;
        end
      end
      prev_grant = grant_o;
      prev_req = req;
    end
  end

  task automatic wait_grant(output int n);
    n = 0;
    while (grant_o == 4'd0 && n < 20) begin tick(); n++; end
    if (grant_o == 4'd0) note_fail("grant_timeout", n);
  endtask

  task automatic wait_hdr(output logic [15:0] hl);
    int n = 0;
    while (!byte_num_en_o && n < 10) begin tick(); n++; end
    if (!byte_num_en_o) note_fail("hdr_timeout", n);
    hl = byte_num_o;
  endtask

  task automatic wait_err(input int k, output int n);
    n = 0;
    while (!err_o[k] && n < 40) begin tick(); n++; end
    if (!err_o[k]) note_fail("err_timeout", n);
    else check("err_lit", err_o, 1 << k);
  endtask

  task automatic send_beats(input int k, input int len, input int nbeats, input int gap,
                            input logic [7:0] base, input bit early_ack);
    for (int i = 0; i < nbeats; i++) begin
      vld[k] = 1'b1;
      bdata[8*k +: 8] = beat(base, i);
      tick();
      vld[k] = 1'b0;
      if (i < len) check("tx_latency", {tx_en_o, tx_data_o}, {1'b1, beat(base, i)});
      else check("tx_drop", tx_en_o, 0);
      if (early_ack && i == 0) begin
        ack = 1'b1;
        tick();
        ack = 1'b0;
      end else begin
        repeat (gap) tick();
      end
    end
  endtask

  // Runs one frame; returns in the REL cycle with the cycles waited for grant.
  task automatic run_frame(input int k, input int len, input int nbeats, input int gap,
                           input logic [7:0] base, input bit do_ack, input bit early_ack,
                           input logic [3:0] drop_mask, output int wn);
    logic [15:0] hl;
    int          n;
    bit          ok_len = (len != 0) && (len <= 4096);
    int          nexp = (nbeats < len) ? nbeats : len;
    if (ok_len) begin
      exp_hdr.push_back(len);
      for (int i = 0; i < nexp; i++) exp_byte.push_back(int'(beat(base, i)));
      exp_evt.push_back(do_ack ? k : k + 16);
    end else begin
      exp_evt.push_back(k + 16);
    end
    req[k] = 1'b1;
    blen[16*k +: 16] = 16'(len);
    wait_grant(wn);
    check("grant_lit", grant_o, 1 << k);
    if (!ok_len) begin
      wait_err(k, n);
      req = req & ~drop_mask;
      tick();
      return;
    end
    wait_hdr(hl);
    check("hdr_len_lit", hl, len);
    tick();
    send_beats(k, len, nbeats, gap, base, early_ack);
    if (do_ack) begin
      ack = 1'b1;
      #1;
      check("done_lit", done_o, 1 << k);
      tick();
      ack = 1'b0;
      req = req & ~drop_mask;
    end else begin
      wait_err(k, n);
      check("timeout_cycles", n, 16);
      req = req & ~drop_mask;
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wn;
    int order[5] = '{0, 1, 2, 3, 0};
    #1;
    check("reset_outputs", {grant_o, done_o, err_o, busy_o, byte_num_en_o, tx_en_o, byte_num_o},
          0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Round-robin with all four requesting; len=1, ack each frame.
    req = 4'b1111;
    for (int k = 0; k < 4; k++) blen[16*k +: 16] = 16'd1;
    for (int f = 0; f < 5; f++) begin
      run_frame(order[f], 1, 1, 0, 8'(8'h40 + f), 1'b1, 1'b0, (f < 4) ? 4'b0000 : 4'b1111, wn);
      if (f == 0) check("rr_first_latency", wn, 1);
      else check("rr_gap_cycles", wn, 2);
    end
    repeat (3) tick();

    // Single frame A1,B2,C3 on requester 0.
    run_frame(0, 3, 3, 0, 8'hA1, 1'b1, 1'b0, 4'b0001, wn);
    check("grant_latency", wn, 1);
    check("rel_grant_low", {grant_o, busy_o}, 5'b00001);
    repeat (3) tick();

    // Zero and oversize length on requester 2.
    run_frame(2, 0, 0, 0, 8'h00, 1'b1, 1'b0, 4'b0100, wn);
    run_frame(2, 4097, 0, 0, 8'h00, 1'b1, 1'b0, 4'b0100, wn);
    check("reject_regrant_gap", wn, 2);
    repeat (3) tick();

    // Ack timeout on requester 3 while requester 1 waits.
    req[1] = 1'b1;
    blen[31:16] = 16'd1;
    run_frame(3, 2, 2, 0, 8'h31, 1'b0, 1'b0, 4'b1000, wn);
    run_frame(1, 1, 1, 0, 8'h51, 1'b1, 1'b0, 4'b0010, wn);
    check("next_pending_gap", wn, 2);
    repeat (3) tick();

    // Gapped data, early ack in DATA, two surplus beats.
    run_frame(2, 4, 6, 1, 8'h61, 1'b1, 1'b1, 4'b0100, wn);
    repeat (3) tick();

    // Reset after 2 of 5 bytes on requester 1.
    exp_hdr.push_back(5);
    exp_byte.push_back(int'(beat(8'h71, 0)));
    exp_byte.push_back(int'(beat(8'h71, 1)));
    req[1] = 1'b1;
    blen[31:16] = 16'd5;
    begin
      logic [15:0] hl;
      wait_grant(wn);
      wait_hdr(hl);
      tick();
      send_beats(1, 5, 2, 0, 8'h71, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame",
          {grant_o, done_o, err_o, busy_o, byte_num_en_o, tx_en_o, tx_data_o, byte_num_o}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_frame(1, 5, 5, 0, 8'h81, 1'b1, 1'b0, 4'b0010, wn);
    check("post_reset_latency", wn, 1);
    repeat (5) tick();

    check("left_hdr", exp_hdr.size(), 0);
    check("left_bytes", exp_byte.size(), 0);
    check("left_events", exp_evt.size(), 0);
    check("tx_total", tx_seen, 22);
    check("hdr_total", hdr_seen, 11);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
